// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared types and constants for the WS2812B frame scheduler.
//   state_e      - scheduler FSM states
//   COLOR_W/CH_W - pixel and channel widths
//   RGB_*/GRB_*  - channel slot indices (slot 2 is the most significant byte)
//   get_ch       - extracts one channel byte from a packed pixel
package ws2812b_pkg;

   localparam int unsigned COLOR_W = 24;
   localparam int unsigned CH_W    = 8;

   // Framebuffer order {R,G,B}
   localparam int unsigned RGB_R = 2;
   localparam int unsigned RGB_G = 1;
   localparam int unsigned RGB_B = 0;

   // Driver order {G,R,B}
   localparam int unsigned GRB_G = 2;
   localparam int unsigned GRB_R = 1;
   localparam int unsigned GRB_B = 0;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait,
      StOffer
   } state_e;

   function automatic logic [CH_W-1:0] get_ch(input logic [COLOR_W-1:0] c,
                                              input int unsigned        slot);
      return c[slot*CH_W +: CH_W];
   endfunction

endpackage

// File: rtl/ws2812b_px_scale.sv
// ws2812b_px_scale: combinational brightness scaling and RGB->GRB reorder.
//   rgb_i - framebuffer pixel {R,G,B}
//   bri_i - global brightness, 0..255
//   grb_o - scaled pixel {G',R',B'}, each channel (c * (bri + 1)) >> 8
module ws2812b_px_scale
   import ws2812b_pkg::*;
(
   input  logic [COLOR_W-1:0] rgb_i,
   input  logic [CH_W-1:0]    bri_i,
   output logic [COLOR_W-1:0] grb_o
);

   // bri + 1 makes 255 an exact pass-through while 0 still blanks the pixel.
   logic [8:0] scale;
   assign scale = {1'b0, bri_i} + 9'd1;

   function automatic logic [CH_W-1:0] mul(input logic [CH_W-1:0] c, input logic [8:0] s);
      logic [16:0] p;
      p = 17'(c) * 17'(s);
      return CH_W'(p >> 8);
   endfunction

   always_comb begin
      grb_o = '0;
      grb_o[GRB_G*CH_W +: CH_W] = mul(get_ch(rgb_i, RGB_G), scale);
      grb_o[GRB_R*CH_W +: CH_W] = mul(get_ch(rgb_i, RGB_R), scale);
      grb_o[GRB_B*CH_W +: CH_W] = mul(get_ch(rgb_i, RGB_B), scale);
   end

endmodule

// File: rtl/ws2812b_frame_sched.sv
// ws2812b_frame_sched: walks a synchronous-read RGB framebuffer and feeds scaled GRB pixels
// to the WS2812B serial driver, on a start request or a periodic refresh tick.
//   clk20_i, reset_i      - clock and asynchronous active-high reset
//   start_i, auto_en_i    - frame request / enable for periodic refresh requests
//   brightness_i          - global scale, captured at frame start
//   busy_o, frame_done_o  - frame in progress / one-cycle end-of-frame pulse
//   fb_addr_o, fb_rd_o    - framebuffer read port, data on fb_rdata_i one cycle later
//   px_data_o, px_valid_o, px_latch_o, px_ready_i - driver handshake
module ws2812b_frame_sched
   import ws2812b_pkg::*;
#(
   parameter int unsigned NUM_LEDS       = 64,
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned REFRESH_CYCLES = 333333
) (
   input  logic               clk20_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               auto_en_i,
   input  logic [CH_W-1:0]    brightness_i,
   output logic               busy_o,
   output logic               frame_done_o,
   output logic [ADDR_W-1:0]  fb_addr_o,
   output logic               fb_rd_o,
   input  logic [COLOR_W-1:0] fb_rdata_i,
   output logic [COLOR_W-1:0] px_data_o,
   output logic               px_valid_o,
   output logic               px_latch_o,
   input  logic               px_ready_i
);

   localparam int unsigned      CNT_W    = $clog2(REFRESH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_LEDS - 1);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pending_q, pending_d;
   logic [CH_W-1:0]      bri_q, bri_d;
   logic [COLOR_W-1:0]   px_data_q, px_data_d;
   logic                 px_latch_q, px_latch_d;
   logic                 frame_done_q, frame_done_d;

   logic                 tick;
   logic                 req;
   logic                 handshake;
   logic                 last_px;
   logic [COLOR_W-1:0]   scaled;

   ws2812b_px_scale u_px_scale (
      .rgb_i (fb_rdata_i),
      .bri_i (bri_q),
      .grb_o (scaled)
   );

   assign tick      = (cnt_q == CNT_LAST);
   // A new request is seen in the same cycle it arrives so IDLE can leave on that edge.
   assign req       = pending_q | start_i | (tick & auto_en_i);
   assign handshake = (state_q == StOffer) & px_ready_i;
   assign last_px   = (idx_q == IDX_LAST);

   // State register
   always_ff @(posedge clk20_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req) state_d = StFetch;
         StFetch: state_d = StWait;
         StWait:  state_d = StOffer;
         StOffer: if (handshake) state_d = last_px ? StIdle : StFetch;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy_o       = (state_q != StIdle);
      fb_rd_o      = (state_q == StFetch);
      px_valid_o   = (state_q == StOffer);
      fb_addr_o    = idx_q;
      px_data_o    = px_data_q;
      px_latch_o   = px_latch_q;
      frame_done_o = frame_done_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
      // IDLE either consumes the request or has none to hold; elsewhere requests accumulate.
      pending_d    = (state_q == StIdle) ? 1'b0 : req;
      idx_d        = idx_q;
      bri_d        = bri_q;
      px_data_d    = px_data_q;
      px_latch_d   = px_latch_q;
      frame_done_d = handshake & last_px;

      if ((state_q == StIdle) && req) begin
         idx_d = '0;
         bri_d = brightness_i;
      end
      if (state_q == StWait) begin
         px_data_d  = scaled;
         px_latch_d = last_px;
      end
      if (handshake) begin
         px_latch_d = 1'b0;
         if (!last_px) idx_d = idx_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk20_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         idx_q        <= '0;
         bri_q        <= '0;
         px_data_q    <= '0;
         px_latch_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         idx_q        <= idx_d;
         bri_q        <= bri_d;
         px_data_q    <= px_data_d;
         px_latch_q   <= px_latch_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_ws2812b_frame_sched.sv
// Self-checking bench for ws2812b_frame_sched (NUM_LEDS=4, REFRESH_CYCLES=200).
module tb_ws2812b_frame_sched;

   localparam int unsigned NL = 4;
   localparam int unsigned AW = 2;
   localparam int unsigned RC = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          auto_en;
   logic [7:0]    bri;
   logic          busy;
   logic          fdone;
   logic [AW-1:0] addr;
   logic          rd;
   logic [23:0]   rdata;
   logic [23:0]   px;
   logic          valid;
   logic          latch;
   logic          ready;

   always #5 clk = ~clk;

   ws2812b_frame_sched #(
      .NUM_LEDS       (NL),
      .ADDR_W         (AW),
      .REFRESH_CYCLES (RC)
   ) dut (
      .clk20_i      (clk),
      .reset_i      (rst),
      .start_i      (start),
      .auto_en_i    (auto_en),
      .brightness_i (bri),
      .busy_o       (busy),
      .frame_done_o (fdone),
      .fb_addr_o    (addr),
      .fb_rd_o      (rd),
      .fb_rdata_i   (rdata),
      .px_data_o    (px),
      .px_valid_o   (valid),
      .px_latch_o   (latch),
      .px_ready_i   (ready)
   );

   // Framebuffer with one-cycle read latency
   logic [23:0] fb [NL];
   initial rdata = '0;
   always @(posedge clk) if (rd) rdata <= fb[addr];

   typedef struct packed {
      logic [23:0] px;
      logic        latch;
   } exp_t;

   typedef struct {
      logic [23:0] rgb;
      logic [7:0]  b;
      logic [23:0] exp;
   } vec_t;

   exp_t       sbq[$];
   int         starts[$];
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         rd_cnt = 0;
   int         hs_cnt = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         last_rd_cyc = 0;
   logic       mon_en = 1'b0;
   logic [7:0] sb_bri = 8'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
      int p;
      p = int'(c) * (int'(b) + 1);
      return 8'(p / 256);
   endfunction

   function automatic logic [23:0] model(input logic [23:0] rgb, input logic [7:0] b);
      return {sc(rgb[15:8], b), sc(rgb[23:16], b), sc(rgb[7:0], b)};
   endfunction

   // Monitor and scoreboard, sampled on the falling edge
   initial begin : mon
      logic        pv = 1'b0;
      logic        phs = 1'b0;
      logic        pl = 1'b0;
      logic        pbusy = 1'b0;
      logic [23:0] pd = '0;
      exp_t        en;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pv = 1'b0;
            phs = 1'b0;
            pbusy = 1'b0;
         end else begin
            if (pv && !phs) begin
               chk("valid_hold", 32'(valid), 32'd1);
               chk("data_hold", 32'(px), 32'(pd));
               chk("latch_hold", 32'(latch), 32'(pl));
            end
            if (rd) begin
               rd_cnt++;
               last_rd_cyc = cyc;
               en.px = model(fb[addr], sb_bri);
               en.latch = (addr == AW'(NL - 1));
               sbq.push_back(en);
            end
            if (valid && !pv) chk("rd_to_valid", 32'(cyc - last_rd_cyc), 32'd2);
            if (busy && !pbusy) starts.push_back(cyc);
            if (valid && ready) begin
               hs_cnt++;
               if (sbq.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL sb_underflow: got handshake expected none (cycle %0d)", cyc);
               end else begin
                  e = sbq.pop_front();
                  chk("px_data", 32'(px), 32'(e.px));
                  chk("px_latch", 32'(latch), 32'(e.latch));
               end
            end
            if (fdone) begin
               done_cnt++;
               done_cyc = cyc;
               chk("busy_at_done", 32'(busy), 32'd0);
               chk("sb_empty_at_done", 32'(sbq.size()), 32'd0);
            end
            pv = valid;
            phs = valid && ready;
            pl = latch;
            pd = px;
            pbusy = busy;
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(fdone), 32'd0);
      chk({tag, "_addr"}, 32'(addr), 32'd0);
      chk({tag, "_rd"}, 32'(rd), 32'd0);
      chk({tag, "_px"}, 32'(px), 32'd0);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_latch"}, 32'(latch), 32'd0);
   endtask

   task automatic pulse_start(input logic expect_fetch);
      @(posedge clk);
      #1 start = 1'b1;
      sb_bri = bri;
      @(posedge clk);
      #1 start = 1'b0;
      if (expect_fetch) begin
         chk("start_fb_rd", 32'(rd), 32'd1);
         chk("start_fb_addr", 32'(addr), 32'd0);
         chk("start_busy", 32'(busy), 32'd1);
      end
   endtask

   task automatic wait_done(input int max);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < max && done_cnt == d0; i++) @(posedge clk);
      chk("done_timeout", 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic wait_valid(input int max);
      for (int i = 0; i < max && !valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("valid_timeout", 32'(valid), 32'd1);
   endtask

   task automatic wait_hs(input int target, input int max);
      for (int i = 0; i < max && hs_cnt < target; i++) @(posedge clk);
      chk("hs_timeout", 32'(hs_cnt >= target), 32'd1);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < int'(NL); i++) fb[i] = {8'(16 * i), 8'hA0, 8'h05};
   endtask

   vec_t vt[6];

   initial begin
      int          hs0;
      int          d0;
      int          s0;
      int          s1;
      int          r0;
      int          dc;
      logic [23:0] snap_px;
      logic        snap_latch;

      vt[0] = '{24'hFF8001, 8'd127, 24'h407F00};
      vt[1] = '{24'hFF8001, 8'd0,   24'h000000};
      vt[2] = '{24'hFF8001, 8'd255, 24'h80FF01};
      vt[3] = '{24'h123456, 8'd255, 24'h341256};
      vt[4] = '{24'hFFFFFF, 8'd128, 24'h808080};
      vt[5] = '{24'h102030, 8'd63,  24'h08040C};

      rst = 1'b1;
      start = 1'b0;
      auto_en = 1'b0;
      bri = 8'd0;
      ready = 1'b0;
      load_ramp();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;

      // Four-pixel frame at full brightness; brightness change after start must not apply
      bri = 8'd255;
      ready = 1'b1;
      hs0 = hs_cnt;
      d0 = done_cnt;
      pulse_start(1'b1);
      bri = 8'd0;
      wait_done(100);
      repeat (5) @(posedge clk);
      chk("frame1_hs", 32'(hs_cnt - hs0), 32'd4);
      chk("frame1_done", 32'(done_cnt - d0), 32'd1);

      // Scaling vectors
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < int'(NL); i++) fb[i] = vt[v].rgb;
         bri = vt[v].b;
         pulse_start(1'b1);
         wait_valid(20);
         chk($sformatf("vec%0d_px", v), 32'(px), 32'(vt[v].exp));
         wait_done(100);
      end

      // Stall pixel 1 for 50 cycles
      load_ramp();
      bri = 8'd255;
      ready = 1'b1;
      hs0 = hs_cnt;
      pulse_start(1'b1);
      wait_hs(hs0 + 1, 50);
      @(posedge clk);
      #1 ready = 1'b0;
      wait_valid(20);
      snap_px = px;
      snap_latch = latch;
      r0 = rd_cnt;
      repeat (50) @(posedge clk);
      #1;
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_px", 32'(px), 32'(snap_px));
      chk("stall_px_val", 32'(px), 32'(model(fb[1], 8'd255)));
      chk("stall_latch", 32'(latch), 32'(snap_latch));
      chk("stall_no_rd", 32'(rd_cnt - r0), 32'd0);
      ready = 1'b1;
      wait_done(100);

      // Two starts while busy collapse into one follow-on frame
      repeat (5) @(posedge clk);
      d0 = done_cnt;
      s0 = starts.size();
      pulse_start(1'b1);
      repeat (2) @(posedge clk);
      pulse_start(1'b0);
      pulse_start(1'b0);
      wait_done(100);
      dc = done_cyc;
      wait_done(100);
      repeat (40) @(posedge clk);
      chk("dbl_frames", 32'(done_cnt - d0), 32'd2);
      chk("dbl_starts", 32'(starts.size() - s0), 32'd2);
      if (starts.size() >= s0 + 2) chk("dbl_gap", 32'(starts[s0 + 1] - dc), 32'd1);

      // Periodic refresh with a randomly stalling driver
      auto_en = 1'b1;
      s0 = starts.size();
      for (int i = 0; i < 700; i++) begin
         @(posedge clk);
         #1 ready = 1'($urandom_range(0, 1));
      end
      chk("auto_nstarts", 32'(starts.size() - s0 >= 3), 32'd1);
      for (int k = s0 + 1; k < starts.size(); k++)
         chk("auto_period", 32'(starts[k] - starts[k - 1]), RC);
      auto_en = 1'b0;
      ready = 1'b1;
      repeat (250) @(posedge clk);
      s1 = starts.size();
      repeat (450) @(posedge clk);
      chk("auto_off", 32'(starts.size() - s1), 32'd0);

      // Reset while pixel 2 is being offered
      hs0 = hs_cnt;
      pulse_start(1'b1);
      wait_hs(hs0 + 2, 50);
      @(posedge clk);
      #1 ready = 1'b0;
      wait_valid(20);
      chk("pre_rst_addr", 32'(addr), 32'd2);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ready = 1'b1;
      mon_en = 1'b1;
      r0 = rd_cnt;
      s0 = starts.size();
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_no_rd", 32'(rd_cnt - r0), 32'd0);
      chk("post_rst_no_start", 32'(starts.size() - s0), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
